// File: rtl/vrf_read_pipe_if.sv
// Signal bundle between the arbitrated requester/SRAM environment (master) and the VRF read stage (slave).
interface vrf_read_pipe_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [4:0]            req_vs;
    logic [3:0]            req_offset;
    logic [3:0]            req_readSource;
    logic [2:0]            req_instructionIndex;
    logic                  sram_en;
    logic [8:0]            sram_addr;
    logic [DATA_WIDTH-1:0] sram_rdata;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_data;
    logic [3:0]            resp_readSource;
    logic [2:0]            resp_instructionIndex;
    logic                  busy;

    modport master (
        output req_valid, req_vs, req_offset, req_readSource, req_instructionIndex,
        input  req_ready,
        input  sram_en, sram_addr,
        output sram_rdata,
        input  resp_valid, resp_data, resp_readSource, resp_instructionIndex,
        output resp_ready,
        input  busy
    );

    modport slave (
        input  req_valid, req_vs, req_offset, req_readSource, req_instructionIndex,
        output req_ready,
        output sram_en, sram_addr,
        input  sram_rdata,
        output resp_valid, resp_data, resp_readSource, resp_instructionIndex,
        input  resp_ready,
        output busy
    );
endinterface

// File: rtl/vrf_read_pipe.sv
// Fixed-latency VRF bank read stage: issues SRAM reads, realigns tags with the returning
// data and buffers responses in a credit-protected FIFO so nothing is dropped under backpressure.
module vrf_read_pipe #(
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 2,
    parameter int RESP_DEPTH   = 4
) (
    input  logic           clock,
    input  logic           reset,
    vrf_read_pipe_if.slave bus
);
    localparam int CW = $clog2(RESP_DEPTH + 1);
    localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

    typedef struct packed {
        logic [3:0] read_source;
        logic [2:0] instruction_index;
    } tag_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        tag_t                  tag;
    } entry_t;

    logic [READ_LATENCY-1:0] pipe_valid;
    tag_t                    pipe_tag [READ_LATENCY];
    entry_t                  mem [RESP_DEPTH];
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    logic [CW-1:0]           count;
    logic [CW-1:0]           credit;
    logic                    fire;
    logic                    capture;
    logic                    pop;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Credit covers in-flight reads as well as buffered entries, so a capture always finds room.
    assign bus.req_ready = (credit < CW'(RESP_DEPTH)) && !reset;
    assign fire          = bus.req_valid && bus.req_ready;
    assign bus.sram_en   = fire;
    assign bus.sram_addr = {bus.req_vs, bus.req_offset};

    assign capture        = pipe_valid[READ_LATENCY-1];
    assign bus.resp_valid = (count != '0);
    assign pop            = bus.resp_valid && bus.resp_ready;
    assign bus.busy       = (credit != '0);
    assign {bus.resp_data, bus.resp_readSource, bus.resp_instructionIndex} = mem[rd_ptr];

    // NOTE: non-blocking assignments keep every stage reading the pre-edge value of its predecessor.
    always_ff @(posedge clock) begin
        if (reset) begin
            pipe_valid <= '0;
        end else begin
            pipe_valid[0] <= fire;
            for (int i = 1; i < READ_LATENCY; i++) pipe_valid[i] <= pipe_valid[i-1];
        end
    end

    always_ff @(posedge clock) begin
        pipe_tag[0] <= {bus.req_readSource, bus.req_instructionIndex};
        for (int i = 1; i < READ_LATENCY; i++) pipe_tag[i] <= pipe_tag[i-1];
    end

    // NOTE: storage is not reset; validity lives entirely in count/pointers, which are.
    always_ff @(posedge clock) begin
        if (capture) mem[wr_ptr] <= '{data: bus.sram_rdata, tag: pipe_tag[READ_LATENCY-1]};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            credit <= '0;
        end else begin
            if (capture) wr_ptr <= wrap_inc(wr_ptr);
            if (pop)     rd_ptr <= wrap_inc(rd_ptr);
            // NOTE: the empty default leaves the register unchanged; in a flop this is a hold, not a latch.
            case ({capture, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            case ({fire, pop})
                2'b10:   credit <= credit + 1'b1;
                2'b01:   credit <= credit - 1'b1;
                default: ;
            endcase
        end
    end

    no_overflow: assert property (@(posedge clock) disable iff (reset)
        !(capture && (count == CW'(RESP_DEPTH)) && !pop));
endmodule

// File: tb/tb_vrf_read_pipe.sv
// Scoreboard bench for vrf_read_pipe: stimulus pushes expected responses, a negedge monitor pops and compares.
module tb_vrf_read_pipe;
    localparam int DW    = 32;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [3:0]    src;
        logic [2:0]    idx;
    } resp_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    int            checks = 0;
    int            passed = 0;
    resp_t         exp_q[$];
    logic [DW-1:0] mem [512];

    vrf_read_pipe_if #(.DATA_WIDTH(DW)) bus ();

    vrf_read_pipe #(
        .DATA_WIDTH(DW),
        .READ_LATENCY(LAT),
        .RESP_DEPTH(DEPTH)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;

    // SRAM model: data for the address presented with sram_en appears two cycles later.
    logic       d1_en = 1'b0;
    logic       d2_en = 1'b0;
    logic [8:0] d1_addr = '0;
    logic [8:0] d2_addr = '0;
    always @(posedge clock) begin
        d1_en   <= bus.sram_en;
        d1_addr <= bus.sram_addr;
        d2_en   <= d1_en;
        d2_addr <= d1_addr;
    end
    assign bus.sram_rdata = d2_en ? mem[d2_addr] : 32'hBAD0_BAD0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic resp_t expect_of(input logic [8:0] addr, input logic [3:0] src, input logic [2:0] idx);
        return '{data: mem[addr], src: src, idx: idx};
    endfunction

    // Monitor: compares every popped response with the oldest expected one and checks hold-stability.
    logic  hold_pending = 1'b0;
    resp_t hold_val = '0;
    always @(negedge clock) begin
        resp_t got;
        resp_t exp;
        if (reset) begin
            hold_pending <= 1'b0;
        end else begin
            got = '{data: bus.resp_data, src: bus.resp_readSource, idx: bus.resp_instructionIndex};
            if (hold_pending) begin
                check("resp_hold_valid", 64'(bus.resp_valid), 64'd1);
                check("resp_hold_payload", 64'(got), 64'(hold_val));
            end
            hold_pending <= bus.resp_valid && !bus.resp_ready;
            hold_val     <= got;
            if (bus.resp_valid && bus.resp_ready) begin
                check("resp_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    exp = exp_q.pop_front();
                    check("resp_payload", 64'(got), 64'(exp));
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic mid();
        @(negedge clock);
    endtask

    // One cycle of stimulus; fields derive from n so a stalled request stays stable while n is unchanged.
    task automatic issue_cycle(input bit v, input int n, input bit rr, output bit fired);
        next_cycle();
        bus.req_valid            = v;
        bus.req_vs               = 5'(n * 3 + 1);
        bus.req_offset           = 4'(n * 5);
        bus.req_readSource       = 4'(n * 7 + 2);
        bus.req_instructionIndex = 3'(n + 1);
        bus.resp_ready           = rr;
        mid();
        fired = v && bus.req_ready;
        if (fired)
            exp_q.push_back(expect_of({bus.req_vs, bus.req_offset}, bus.req_readSource, bus.req_instructionIndex));
    endtask

    task automatic drain(input string name);
        int budget = 0;
        next_cycle();
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        mid();
        while ((exp_q.size() != 0 || bus.busy) && budget < 100) begin
            next_cycle();
            mid();
            budget++;
        end
        check({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
        check({name, "_busy_clear"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit fired;
        int n;
        int first;
        int last;
        int nvalid;

        for (int i = 0; i < 512; i++) mem[i] = 32'h5A00_0000 ^ (i * 32'h0001_0203);
        mem[9'h032] = 32'hDEAD_BEEF;

        bus.req_valid            = 1'b0;
        bus.req_vs               = '0;
        bus.req_offset           = '0;
        bus.req_readSource       = '0;
        bus.req_instructionIndex = '0;
        bus.resp_ready           = 1'b0;

        // Reset state
        reset = 1'b1;
        repeat (3) next_cycle();
        mid();
        check("rst_req_ready", 64'(bus.req_ready), 64'd0);
        check("rst_sram_en", 64'(bus.sram_en), 64'd0);
        check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        next_cycle();
        reset = 1'b0;
        bus.resp_ready = 1'b1;
        mid();
        check("req_ready_after_reset", 64'(bus.req_ready), 64'd1);

        // Single read with hand-computed address and data
        next_cycle();
        bus.req_valid            = 1'b1;
        bus.req_vs               = 5'h03;
        bus.req_offset           = 4'h2;
        bus.req_readSource       = 4'h9;
        bus.req_instructionIndex = 3'h5;
        mid();
        check("single_sram_en", 64'(bus.sram_en), 64'd1);
        check("single_sram_addr", 64'(bus.sram_addr), 64'h032);
        check("single_req_ready", 64'(bus.req_ready), 64'd1);
        if (bus.req_valid && bus.req_ready)
            exp_q.push_back('{data: 32'hDEAD_BEEF, src: 4'h9, idx: 3'h5});
        for (int k = 1; k <= 3; k++) begin
            next_cycle();
            bus.req_valid = 1'b0;
            mid();
            check("single_latency_valid", 64'(bus.resp_valid), 64'(k == 3));
            if (k == 3) begin
                check("single_data", 64'(bus.resp_data), 64'hDEAD_BEEF);
                check("single_src", 64'(bus.resp_readSource), 64'h9);
                check("single_idx", 64'(bus.resp_instructionIndex), 64'h5);
            end
        end
        next_cycle();
        mid();
        check("single_busy_after_pop", 64'(bus.busy), 64'd0);
        check("single_valid_after_pop", 64'(bus.resp_valid), 64'd0);

        // Streaming: 16 back-to-back requests, responses on 16 consecutive cycles
        first = -1;
        last = -1;
        nvalid = 0;
        for (int c = 0; c < 22; c++) begin
            issue_cycle(c < 16, c, 1'b1, fired);
            if (c < 16) check("stream_req_ready", 64'(bus.req_ready), 64'd1);
            if (bus.resp_valid) begin
                if (first < 0) first = c;
                last = c;
                nvalid++;
            end
        end
        check("stream_resp_count", 64'(nvalid), 64'd16);
        check("stream_contiguous", 64'(last - first + 1), 64'd16);
        check("stream_first_latency", 64'(first), 64'd3);
        drain("stream");

        // Backpressure: exactly 4 fires, then a pop re-enables req_ready one cycle later
        n = 0;
        for (int c = 0; c < 10; c++) begin
            issue_cycle(1'b1, 200 + n, 1'b0, fired);
            if (fired) n++;
        end
        check("bp_fire_count", 64'(n), 64'd4);
        check("bp_req_ready_full", 64'(bus.req_ready), 64'd0);
        check("bp_busy_full", 64'(bus.busy), 64'd1);
        check("bp_resp_valid_full", 64'(bus.resp_valid), 64'd1);
        issue_cycle(1'b0, 0, 1'b1, fired);
        check("bp_ready_in_pop_cycle", 64'(bus.req_ready), 64'd0);
        issue_cycle(1'b0, 0, 1'b1, fired);
        check("bp_ready_after_pop", 64'(bus.req_ready), 64'd1);
        drain("bp");

        // Full with a pop and a fire every cycle
        n = 0;
        for (int c = 0; c < 6; c++) begin
            issue_cycle(1'b1, 300 + n, 1'b0, fired);
            if (fired) n++;
        end
        check("full_fill_count", 64'(n), 64'd4);
        for (int c = 0; c < 12; c++) begin
            issue_cycle(1'b1, 300 + n, 1'b1, fired);
            if (fired) n++;
            check("full_req_ready", 64'(bus.req_ready), 64'(c != 0));
            check("full_busy", 64'(bus.busy), 64'd1);
        end
        check("full_total_fires", 64'(n), 64'd15);
        drain("full");

        // Reset one cycle after two fires: in-flight reads are discarded
        issue_cycle(1'b1, 400, 1'b1, fired);
        issue_cycle(1'b1, 401, 1'b1, fired);
        next_cycle();
        bus.req_valid = 1'b0;
        reset = 1'b1;
        exp_q.delete();
        mid();
        next_cycle();
        reset = 1'b0;
        mid();
        check("midrst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_req_ready", 64'(bus.req_ready), 64'd1);
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            mid();
            check("midrst_no_stale_resp", 64'(bus.resp_valid), 64'd0);
        end

        // Random tags, request valid and consumer backpressure
        for (int c = 0; c < 80; c++) begin
            issue_cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 1000)), 1'($urandom_range(0, 1)), fired);
        end
        drain("random");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/vrf_read_pipe.md
# vrf_read_pipe

Fixed-latency VRF bank read stage that sits directly downstream of the per-bank two-input read-request round-robin arbiter. It accepts one arbitrated read request per cycle and drives the bank SRAM read port. It captures the read data after a fixed SRAM latency and returns it, tagged with the requester's readSource and instructionIndex, through a credit-protected response FIFO. Responses are never dropped under consumer backpressure.

## Interface
- DATA_WIDTH, 32, SRAM read data width
- READ_LATENCY, 2, cycles from sram_en to valid sram_rdata (>=1)
- RESP_DEPTH, 4, response FIFO entries; also total outstanding-request credit (>=READ_LATENCY)

Ports:
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req_valid  in  1  arbitrated request valid
- req_ready  out  1  request accepted when req_valid & req_ready
- req_vs  in  5  vector register
- req_offset  in  4  offset within register group
- req_readSource  in  4  requester tag, returned unchanged
- req_instructionIndex  in  3  instruction tag, returned unchanged
- sram_en  out  1  SRAM read enable
- sram_addr  out  9  {req_vs, req_offset}
- sram_rdata  in  DATA_WIDTH  SRAM read data, valid READ_LATENCY cycles after sram_en
- resp_valid  out  1  response available
- resp_ready  in  1  consumer accepts response
- resp_data  out  DATA_WIDTH  read data
- resp_readSource  out  4  tag of the request
- resp_instructionIndex  out  3  tag of the request
- busy  out  1  any read in flight or any response buffered

## Operation
- Accept: fire = req_valid & req_ready.
  - sram_en = fire, combinational, same cycle.
  - sram_addr = {req_vs, req_offset}, combinational. Don't-care when sram_en=0.
- Tag pipe: READ_LATENCY-stage shift register of {valid, readSource, instructionIndex}. Stage 0 loads fire and the tags on each cycle.
- Capture: when the last stage is valid, {sram_rdata, tags} is written to the response FIFO at the end of that cycle.
- FIFO:
  - RESP_DEPTH entries, in-order.
  - resp_* driven from the head entry. resp_valid = FIFO not empty.
  - Pop on resp_valid & resp_ready.
- Credit counter, width clog2(RESP_DEPTH+1), counting in-flight reads plus buffered entries:
  - +1 on fire, -1 on pop. Both in the same cycle: unchanged.
  - req_ready = (credit < RESP_DEPTH) & ~reset.
  - req_ready depends only on registered state, so there is no combinational path from resp_ready or req_valid.
- The FIFO cannot overflow by construction. A capture into a full FIFO is an assertion failure.
- busy = (credit != 0).
- Responses leave in strict request order. Tags are never modified.
- Reset, including mid-operation:
  - Pipe valids cleared, FIFO emptied, credit=0.
  - In-flight reads are discarded. Their sram_rdata is ignored.

## Timing
- Reset values:
  - req_ready=0 while reset is high, 1 in the first cycle after.
  - sram_en=0, resp_valid=0, busy=0.
  - resp_data, resp tags and sram_addr are don't-care.
- Latency: request fired in cycle T is captured at the end of cycle T+READ_LATENCY. resp_valid is first high in T+READ_LATENCY+1.
- Throughput: 1 request/cycle sustained when resp_ready=1 continuously.
- Full: credit==RESP_DEPTH gives req_ready=0. A pop in cycle C raises req_ready in C+1.
- Simultaneous capture and pop on the same cycle: both happen, occupancy is unchanged. This is legal when full.
- Empty-FIFO capture: data appears on resp_* the next cycle. There is no same-cycle bypass.
- resp_* hold stable while resp_valid & ~resp_ready.

## Test plan
- Single read, defaults:
  - Stimulus: fire at T with vs=5'h03, offset=4'h2, readSource=4'h9, instructionIndex=3'h5. sram_rdata=32'hDEADBEEF at T+2.
  - Required: sram_en=1 and sram_addr=9'h032 at T. resp_valid at T+3 with data DEADBEEF, tags 9 and 5. busy=0 the cycle after the pop.
- Streaming:
  - Stimulus: 16 back-to-back requests with resp_ready=1.
  - Required: req_ready stays 1. 16 responses in order on consecutive cycles.
- Backpressure:
  - Stimulus: resp_ready=0 with req_valid held.
  - Required: exactly 4 fires, then req_ready=0 and credit=4. Raise resp_ready: the first pop re-enables req_ready next cycle, and the 4 responses emerge in order.
- Full plus simultaneous events:
  - Stimulus: at credit=4, one pop per cycle and one new fire per cycle.
  - Required: credit stays at 3–4. No overflow assertion fires. No response is lost or duplicated.
- Reset mid-flight:
  - Stimulus: assert reset one cycle after 2 fires.
  - Required: after reset, resp_valid=0, busy=0, req_ready=1. The stale sram_rdata produces no response.
- Tag integrity:
  - Stimulus: randomized tags and resp_ready.
  - Required: the scoreboard matches every response to its request in order.
